day_of_year_counter: RTL
========================

# day_of_year_counter

Two-digit BCD day-of-year counter that drives the day-of-year to month/day converter directly downstream. It has pushbutton up/down stepping with on-chip synchronisation and debounce, an optional auto-advance tick, and a parallel load from switches. It outputs the current day as tens/units BCD digits in the range 1..MAX_DAY, plus a one-cycle change strobe. Built for the 50 MHz board clock with active-low pushbuttons.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
- TICK_DIV, 50000000: clock cycles per auto-advance step (1 s at 50 MHz); must be ≥ 2.
- MAX_DAY, 99: highest legal day value; 1 ≤ MAX_DAY ≤ 99.
- clock  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- key_up_n  input  1  raw pushbutton, active low, asynchronous to clock; press = step +1.
- key_down_n  input  1  raw pushbutton, active low, asynchronous; press = step −1.
- auto_en  input  1  level; when high, advance +1 every TICK_DIV cycles.
- load  input  1  level-sampled; when high, load load_msb/load_lsb this cycle.
- load_msb  input  4  BCD tens digit to load.
- load_lsb  input  4  BCD units digit to load.
- MSB  output  4  registered BCD tens digit of current day.
- LSB  output  4  registered BCD units digit of current day.
- changed  output  1  one-cycle pulse in the cycle after MSB/LSB take a new value.
- load_err  output  1  one-cycle pulse when a load is rejected.

## Operation
- Key path, per key: 2-flop synchroniser, then debouncer. Debounced level resets to 1 (released). Stability counter clears whenever synced == debounced. Otherwise it increments; on reaching DEBOUNCE_CYCLES−1 the debounced level takes the synced value and the counter clears.
- Press detect: debounced 1→0 transition gives a one-cycle step_up / step_dn. Release generates nothing. A held key gives exactly one step.
- Tick divider: counts 0..TICK_DIV−1 while auto_en = 1 and pulses tick on the wrap. It clears to 0 whenever auto_en = 0.
- Day register: held internally as BCD digits. Priority per cycle, highest first:
  - load
  - step_up & step_dn simultaneously → no change
  - step_up or tick → +1; step_up and tick together count as a single +1
  - step_dn → −1; step_dn with tick → no change (cancel)
- Increment is BCD: units 9 → 0 with tens +1. If the current value == MAX_DAY, the result wraps to 01.
- Decrement is BCD: units 0 → 9 with tens −1. If the current value == 01, the result wraps to MAX_DAY.
- Load is accepted only if load_msb ≤ 9, load_lsb ≤ 9, and value 10·msb+lsb is in 1..MAX_DAY.
  - Accepted: digits register next edge.
  - Rejected: day unchanged, load_err pulses next cycle.
  - A load held high reloads every cycle. changed fires only when the value actually differs.
- Day 00 is never produced. MSB/LSB are always valid BCD.

## Timing
- Reset values: MSB=0, LSB=1, changed=0, load_err=0, debounced levels=1, all counters 0, synchronisers=1.
- Reset asserted mid-operation forces reset values immediately, asynchronously. Any in-progress debounce or tick count is discarded.
- Key latency: a raw key low that stays stable from edge k updates MSB/LSB at edge k+DEBOUNCE_CYCLES+3. changed is high during the following cycle.
- Glitches shorter than DEBOUNCE_CYCLES cycles (post-sync) produce no step.
- Load latency: load sampled at edge n → MSB/LSB new at edge n. changed or load_err is high for the cycle after edge n+1.
- Auto tick: first step TICK_DIV cycles after auto_en rises, then every TICK_DIV cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
Simulation uses DEBOUNCE_CYCLES=4, TICK_DIV=5, MAX_DAY=99 unless stated.
- Reset, then key_up_n low for 20 cycles → MSB/LSB 0/1 → 0/2 exactly 7 edges after key low, one changed pulse, no further step while held.
- Load 0/9, then one up press → 1/0; load 9/9, then up → 0/1; from 0/1, down press → 9/9.
- key_up_n low 3 cycles, then high → no change, changed never asserts. Both keys pressed on the same cycle → no change.
- Load msb=10 lsb=0, or msb=0 lsb=0 → value unchanged, load_err one-cycle pulse. Load 3/1 → 3/1, changed pulse.
- auto_en=1 from 0/1 for 25 cycles → 0/6, steps spaced 5 cycles. Deassert auto_en, reassert → next step 5 cycles later.
- MAX_DAY=59, load 5/9, auto tick → 0/1. Assert reset_n low mid-debounce of a press → 0/1, and no step after release of reset.

Source files
------------

// File: rtl/day_of_year_counter.sv
// day_of_year_counter: BCD day-of-year (1..MAX_DAY) with debounced up/down keys, auto tick and checked parallel load.
module day_of_year_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV = 50000000,
  parameter int MAX_DAY = 99
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       auto_en,
  input  logic       load,
  input  logic [3:0] load_msb,
  input  logic [3:0] load_lsb,
  output logic [3:0] MSB,
  output logic [3:0] LSB,
  output logic       changed,
  output logic       load_err
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [3:0] MAX_T = 4'(MAX_DAY / 10);
  localparam logic [3:0] MAX_U = 4'(MAX_DAY % 10);
  logic [1:0] keys, s1, s2, deb, deb_d1, step;
  logic [CW-1:0] cnt [2];
  logic [TW-1:0] tcnt;
  logic tick, load_ok, at_max, at_min, do_inc, do_dec, err_q;
  logic [7:0] load_val, prev;
  logic [3:0] inc_t, inc_u, dec_t, dec_u, nxt_t, nxt_u;
  assign keys = {key_down_n, key_up_n};
  // bit 0 is the up key, bit 1 the down key; step is a registered press edge
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      s1 <= '1;
      s2 <= '1;
      deb <= '1;
      deb_d1 <= '1;
      step <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= keys;
      s2 <= s1;
      deb_d1 <= deb;
      step <= deb_d1 & ~deb;
      for (int i = 0; i < 2; i++)
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  assign tick = auto_en && tcnt == TW'(TICK_DIV - 1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) tcnt <= '0;
    else tcnt <= (!auto_en || tick) ? '0 : tcnt + 1'b1;
  assign load_val = {4'd0, load_msb} * 8'd10 + {4'd0, load_lsb};
  assign load_ok = load_msb <= 4'd9 && load_lsb <= 4'd9 && load_val != 8'd0 && load_val <= 8'(MAX_DAY);
  assign at_max = MSB == MAX_T && LSB == MAX_U;
  assign at_min = MSB == 4'd0 && LSB == 4'd1;
  assign inc_t = at_max ? 4'd0 : (LSB == 4'd9 ? MSB + 4'd1 : MSB);
  assign inc_u = at_max ? 4'd1 : (LSB == 4'd9 ? 4'd0 : LSB + 4'd1);
  assign dec_t = at_min ? MAX_T : (LSB == 4'd0 ? MSB - 4'd1 : MSB);
  assign dec_u = at_min ? MAX_U : (LSB == 4'd0 ? 4'd9 : LSB - 4'd1);
  // a tick merges with an up step and cancels a down step
  assign do_inc = ~step[1] & (step[0] | tick);
  assign do_dec = step[1] & ~step[0] & ~tick;
  always_comb begin
    nxt_t = load ? (load_ok ? load_msb : MSB) : do_inc ? inc_t : do_dec ? dec_t : MSB;
    nxt_u = load ? (load_ok ? load_lsb : LSB) : do_inc ? inc_u : do_dec ? dec_u : LSB;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      MSB <= 4'd0;
      LSB <= 4'd1;
      prev <= 8'h01;
      changed <= 1'b0;
      err_q <= 1'b0;
      load_err <= 1'b0;
    end else begin
      MSB <= nxt_t;
      LSB <= nxt_u;
      prev <= {MSB, LSB};
      changed <= {MSB, LSB} != prev;
      err_q <= load & ~load_ok;
      load_err <= err_q;
    end
endmodule
